// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit constants and converter state encoding
package bcd_pkg;

  localparam int DIGIT_W = 4;

  // Reverse (BCD-to-binary) correction: digits >= 8 after a right shift lose 3
  localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_VAL    = 4'd3;

  // Forward (binary-to-BCD) correction used by the display path
  localparam logic [DIGIT_W-1:0] BCD_FWD_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_FWD_VAL    = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - single-digit reverse double-dabble correction
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit - BCD_ADJ_VAL) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential reverse double-dabble BCD-to-binary converter
// Optional macro BCD_CHECK_EN adds the bcd_err output flagging accepted digits above 9.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGITS*4-1:0]     bcd_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_W-1:0]        bin_out
`ifdef BCD_CHECK_EN
  ,
  output logic                    bcd_err
`endif
);

  localparam int BCD_W = DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             r_state;
  logic [BCD_W-1:0]   r_bcd;
  logic [BIN_W-1:0]   r_bin;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [BIN_W-1:0]   r_bin_out;

  logic [BCD_W+BIN_W-1:0] w_shift;
  logic [BCD_W-1:0]       w_bcd_sh;
  logic [BCD_W-1:0]       w_bcd_adj;
  logic [BIN_W-1:0]       w_bin_next;

  // One iteration: shift the joint register right, then correct each digit on its own
  assign w_shift    = {r_bcd, r_bin} >> 1;
  assign w_bcd_sh   = w_shift[BCD_W+BIN_W-1:BIN_W];
  assign w_bin_next = w_shift[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (w_bcd_sh[g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD_CHECK_EN
  logic w_illegal;
  logic r_bcd_err;

  always_comb begin
    w_illegal = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_in[k*DIGIT_W +: DIGIT_W] > 4'd9) w_illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd_err <= 1'b0;
    end else if (r_state == ST_IDLE && in_valid) begin
      r_bcd_err <= w_illegal;
    end
  end

  assign bcd_err = r_bcd_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bcd       <= '0;
      r_bin       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bin_out   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_bcd      <= bcd_in;
            r_bin      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd <= w_bcd_adj;
          r_bin <= w_bin_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_bin_out   <= w_bin_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Consume edge returns to IDLE; a new accept is only possible on the next edge
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign bin_out   = r_bin_out;

endmodule
